banner_scan_reader: RTL and testbench

- Reader side of the 3-bit banner bitmap ROMs (20x15 cells, 300 entries, one colour code per cell, code 0 = transparent).
- Takes the VGA pixel position and produces the ROM address.
- Registers the returned colour and gates it with a frame-synchronised display state machine, so the banner appears and disappears only on frame boundaries.
- Sits between the VGA timing generator and the final pixel mux.

---
 rtl/banner_scan_reader.sv | 133 +++++++++++++
 tb/tb_banner_scan_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/banner_scan_reader.sv
module banner_scan_reader #(
  parameter int unsigned BMP_W        = 20,
  parameter int unsigned BMP_H        = 15,
  parameter int unsigned SCALE_SHIFT  = 3,
  parameter int unsigned ORG_X        = 240,
  parameter int unsigned ORG_Y        = 180,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic       show,
  output logic [8:0] rom_addr,
  input  logic [2:0] rom_q,
  output logic [2:0] pix_color,
  output logic       pix_opaque,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ARMED, DISPLAY} state_t;

  localparam logic [10:0] X_LO = 11'(ORG_X);
  localparam logic [10:0] X_HI = 11'(ORG_X + (BMP_W << SCALE_SHIFT));
  localparam logic [10:0] Y_LO = 11'(ORG_Y);
  localparam logic [10:0] Y_HI = 11'(ORG_Y + (BMP_H << SCALE_SHIFT));

  state_t     state_q, state_d;
  logic [8:0] rom_addr_q, rom_addr_d;
  logic       win_q, win_d;
  logic [2:0] pix_color_q, pix_color_d;
  logic       pix_opaque_q, pix_opaque_d;
  logic       busy_q, busy_d;

  logic       in_win;
  logic [9:0] dx, dy;
  logic [8:0] col, row, row_off, addr;

`ifdef BANNER_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;
`endif

  // row*BMP_W built from shifted copies of row, one per set bit of BMP_W.
  always_comb begin
    in_win = video_on
          && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI)
          && ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    dx  = pixel_x - X_LO[9:0];
    dy  = pixel_y - Y_LO[9:0];
    col = 9'(dx >> SCALE_SHIFT);
    row = 9'(dy >> SCALE_SHIFT);
    row_off = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (BMP_W[i]) row_off = row_off + (row << i);
    end
    addr = row_off + col;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (show) state_d = ARMED;
      ARMED: begin
        if (!show)            state_d = IDLE;
        else if (frame_start) state_d = DISPLAY;
      end
      DISPLAY: if (frame_start && !show) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DISPLAY);

    rom_addr_d   = in_win ? addr : '0;
    win_d        = in_win && (state_q == DISPLAY);
    pix_color_d  = win_q ? rom_q : '0;
    pix_opaque_d = win_q && (rom_q != '0);

`ifdef BANNER_BLINK_EN
    win_d       = win_d && blink_on_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (state_d != DISPLAY) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b0;
    end else if (state_q != DISPLAY) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      rom_addr_q   <= '0;
      win_q        <= 1'b0;
      pix_color_q  <= '0;
      pix_opaque_q <= 1'b0;
`ifdef BANNER_BLINK_EN
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      rom_addr_q   <= rom_addr_d;
      win_q        <= win_d;
      pix_color_q  <= pix_color_d;
      pix_opaque_q <= pix_opaque_d;
`ifdef BANNER_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
`endif
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pix_color  = pix_color_q;
  assign pix_opaque = pix_opaque_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_banner_scan_reader.sv
module tb_banner_scan_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_start, show;
  logic [8:0] rom_addr;
  logic [2:0] rom_q;
  logic [2:0] pix_color;
  logic       pix_opaque, busy;

  always #5 clk = ~clk;

`ifdef BANNER_BLINK_EN
  localparam int unsigned BLINK_N = 2;
`else
  localparam int unsigned BLINK_N = 30;
`endif

  banner_scan_reader #(.BLINK_FRAMES(BLINK_N)) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .show(show),
    .rom_addr(rom_addr), .rom_q(rom_q), .pix_color(pix_color),
    .pix_opaque(pix_opaque), .busy(busy)
  );

  function automatic logic [2:0] rom_val(input logic [8:0] a);
    if (a == 9'd0) return 3'd0;
    return 3'(a + 9'd7);
  endfunction

  always_comb rom_q = rom_val(rom_addr);

  typedef struct {
    int          cyc;
    string       name;
    int unsigned sel;
    int unsigned exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sample(input int unsigned sel);
    case (sel)
      0:       return int'(rom_addr);
      1:       return int'(pix_color);
      2:       return int'(pix_opaque);
      default: return int'(busy);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.cyc < cyc) chk({e.name, "_missed_cycle"}, cyc, e.cyc);
      else             chk(e.name, sample(e.sel), e.exp);
    end
  end

  task automatic expect_at(input int d, input string n, input int unsigned sel, input int unsigned v);
    exp_t e;
    e.cyc = cyc + d; e.name = n; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input string n, input int x, input int y, input bit von,
                       input int unsigned ea, input bit vis);
    int unsigned c;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    c = vis ? int'(rom_val(9'(ea))) : 0;
    expect_at(1, {n, "_addr"}, 0, ea);
    expect_at(2, {n, "_color"}, 1, c);
    expect_at(2, {n, "_opaque"}, 2, (c != 0) ? 1 : 0);
    step();
  endtask

  task automatic frame(input bit s, input bit exp_busy);
    frame_start = 1'b1;
    show        = s;
    expect_at(1, "busy_after_frame", 3, exp_busy);
    step();
    frame_start = 1'b0;
  endtask

  int vx[12]  = '{240, 247, 248, 240, 399, 288, 320, 248, 239, 400, 240, 300};
  int vy[12]  = '{180, 187, 180, 188, 299, 180, 240, 180, 180, 180, 300, 200};
  bit vv[12]  = '{1,   1,   1,   1,   1,   1,   1,   1,   1,   1,   1,   0};
  int va[12]  = '{0,   0,   1,   20,  299, 6,   150, 1,   0,   0,   0,   0};
  bit vvis[12] = '{1,  1,   1,   1,   1,   1,   1,   1,   0,   0,   0,   0};

  initial begin
    rst = 1'b1;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0; frame_start = 1'b0; show = 1'b0;
    #12;
    chk("reset_addr", rom_addr, 0);
    chk("reset_color", pix_color, 0);
    chk("reset_opaque", pix_opaque, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    frame(1'b1, 1'b0);
    drive("armed", 288, 180, 1'b1, 6, 1'b0);
    frame(1'b1, 1'b1);

    for (int unsigned i = 0; i < 12; i++)
      drive($sformatf("vec%0d", i), vx[i], vy[i], vv[i], va[i], vvis[i]);

    show = 1'b0;
    expect_at(1, "busy_hold", 3, 1);
    drive("drop_mid", 288, 180, 1'b1, 6, 1'b1);
    frame(1'b0, 1'b0);
    drive("after_drop", 288, 180, 1'b1, 6, 1'b0);

`ifdef BANNER_BLINK_EN
    show = 1'b1;
    step();
    frame(1'b1, 1'b1);
    for (int unsigned f = 0; f < 6; f++) begin
      drive($sformatf("blink_f%0d", f), 288, 180, 1'b1, 6, ((f / 2) % 2) == 0);
      frame(1'b1, 1'b1);
    end
    frame(1'b0, 1'b0);
`endif

    show = 1'b1;
    step();
    frame(1'b1, 1'b1);
    for (int unsigned k = 0; k < 3; k++) drive("pre_reset", 288, 180, 1'b1, 6, 1'b1);
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("async_rst_addr", rom_addr, 0);
    chk("async_rst_color", pix_color, 0);
    chk("async_rst_opaque", pix_opaque, 0);
    chk("async_rst_busy", busy, 0);
    show = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    expect_at(1, "post_rst_busy", 3, 0);
    step();
    frame(1'b1, 1'b0);
    drive("post_rst_pix", 288, 180, 1'b1, 6, 1'b0);

    repeat (5) step();
    if (sbq.size() != 0) chk("scoreboard_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
